// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I memory-access stage: byte/half/word loads and stores
// against a byte-writable word RAM, with a ready/ack handshake and optional wait states.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wr,
    input  logic [1:0]  i_data_rd_en_ctrl,
    input  logic        i_data_unsigned,
    input  logic        i_data_rd_en_ma,
    input  logic        i_data_wr_en_ma,
    output logic [31:0] o_data_rd,
    output logic        o_data_ready,
    output logic        o_data_ack,
    output logic        o_data_err
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t             state, next_state;
    logic [3:0]         wait_cnt;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wr_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic               store_q;
    logic               err_q;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        mem_word;
    logic [ADDR_W-1:0]  word_idx;
    logic [1:0]         off;
    logic [3:0]         byte_en;
    logic [31:0]        store_data;
    logic [31:0]        load_val;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic               accept;
    logic               req_err;

    // Upper address bits alias onto the RAM and are deliberately discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_data_addr[31:ADDR_W+2];

    assign o_data_ready = (state == S_IDLE);
    assign accept       = (state == S_IDLE) && (i_data_rd_en_ma || i_data_wr_en_ma);
    assign req_err      = (i_data_rd_en_ctrl == 2'b11)
                        || (i_data_rd_en_ctrl == 2'b01 && i_data_addr[0])
                        || (i_data_rd_en_ctrl == 2'b10 && i_data_addr[1:0] != 2'b00)
                        || (i_data_rd_en_ma && i_data_wr_en_ma);

    assign word_idx = addr_q[ADDR_W+1:2];
    assign off      = addr_q[1:0];
    assign mem_word = mem[word_idx];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (wait_cnt == 4'd0) next_state = S_ACCESS;
            S_ACCESS: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        byte_en    = 4'b0000;
        store_data = wr_q;
        load_val   = mem_word;
        case (off)
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        half_sel = off[1] ? mem_word[31:16] : mem_word[15:0];
        case (size_q)
            2'b00: begin
                byte_en    = 4'b0001 << off;
                store_data = {4{wr_q[7:0]}};
                load_val   = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                byte_en    = off[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wr_q[15:0]}};
                load_val   = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            addr_q     <= '0;
            wr_q       <= 32'd0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
            o_data_rd  <= 32'd0;
            o_data_ack <= 1'b0;
            o_data_err <= 1'b0;
        end else begin
            state      <= next_state;
            o_data_ack <= (state == S_ACCESS);
            o_data_err <= (state == S_ACCESS) && err_q;
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
                addr_q   <= i_data_addr[ADDR_W+1:0];
                wr_q     <= i_data_wr;
                size_q   <= i_data_rd_en_ctrl;
                uns_q    <= i_data_unsigned;
                store_q  <= i_data_wr_en_ma;
                err_q    <= req_err;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            // Loads and any errored request update the result; clean stores leave it alone.
            if (state == S_ACCESS && (!store_q || err_q))
                o_data_rd <= err_q ? 32'd0 : load_val;
        end
    end

    // NOTE: RAM contents are not reset; a reset mid-request returns state to IDLE so nothing commits.
    always_ff @(posedge i_clk) begin
        if (state == S_ACCESS && store_q && !err_q) begin
            for (int i = 0; i < 4; i++)
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: a zero-wait instance for the
// access/error/reset/alias cases and a three-wait-state instance for timing and back-to-back.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Zero-wait-state instance
    logic [31:0] addr0 = '0, wdata0 = '0, rd0;
    logic [1:0]  size0 = '0;
    logic        uns0 = 1'b0, rden0 = 1'b0, wren0 = 1'b0;
    logic        ready0, ack0, err0;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_data_addr(addr0), .i_data_wr(wdata0), .i_data_rd_en_ctrl(size0),
        .i_data_unsigned(uns0), .i_data_rd_en_ma(rden0), .i_data_wr_en_ma(wren0),
        .o_data_rd(rd0), .o_data_ready(ready0), .o_data_ack(ack0), .o_data_err(err0)
    );

    // Three-wait-state instance
    logic [31:0] addr3 = '0, wdata3 = '0, rd3;
    logic [1:0]  size3 = '0;
    logic        uns3 = 1'b0, rden3 = 1'b0, wren3 = 1'b0;
    logic        ready3, ack3, err3;

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_data_addr(addr3), .i_data_wr(wdata3), .i_data_rd_en_ctrl(size3),
        .i_data_unsigned(uns3), .i_data_rd_en_ma(rden3), .i_data_wr_en_ma(wren3),
        .o_data_rd(rd3), .o_data_ready(ready3), .o_data_ack(ack3), .o_data_err(err3)
    );

    // One request on dut0; lat counts cycles from the request cycle to the ack cycle.
    task automatic req0(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] size, input logic uns,
                        output int lat, output logic [31:0] rdv, output logic errv);
        @(negedge clk);
        addr0 = addr; wdata0 = data; size0 = size; uns0 = uns; rden0 = rd; wren0 = wr;
        @(negedge clk);
        rden0 = 1'b0; wren0 = 1'b0;
        lat = 1;
        while (!ack0 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        rdv  = rd0;
        errv = err0;
    endtask

    int          lat;
    logic [31:0] rdv;
    logic        errv;

    initial begin
        // Reset state
        #2;
        check("rst_ready", 32'(ready0), 32'd1);
        check("rst_ack",   32'(ack0),   32'd0);
        check("rst_err",   32'(err0),   32'd0);
        check("rst_rd",    rd0,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then load
        req0(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, lat, rdv, errv);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_err", 32'(errv), 32'd0);
        req0(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_data", rdv, 32'hDEADBEEF);
        check("lw_err", 32'(errv), 32'd0);

        // Byte store and signed/unsigned byte loads
        req0(1'b0, 1'b1, 32'h101, 32'h0000007F, 2'b00, 1'b0, lat, rdv, errv);
        req0(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        check("sb_merge", rdv, 32'hDEAD7FEF);
        req0(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, lat, rdv, errv);
        check("lb", rdv, 32'hFFFFFFDE);
        req0(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, lat, rdv, errv);
        check("lbu", rdv, 32'h000000DE);

        // Halfword loads and store
        req0(1'b0, 1'b1, 32'h100, 32'h80011234, 2'b10, 1'b0, lat, rdv, errv);
        req0(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b0, lat, rdv, errv);
        check("lh", rdv, 32'hFFFF8001);
        req0(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, lat, rdv, errv);
        check("lhu", rdv, 32'h00008001);
        req0(1'b0, 1'b1, 32'h102, 32'h0000ABCD, 2'b01, 1'b0, lat, rdv, errv);
        check("sh_rd_hold", rdv, 32'h00008001);
        check("sh_err", 32'(errv), 32'd0);
        req0(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        check("sh_merge", rdv, 32'hABCD1234);

        // Error cases: ack with err, result zero, RAM untouched
        req0(1'b1, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        check("err_lw_mis", 32'(errv), 32'd1);
        check("err_lw_rd", rdv, 32'd0);
        check("err_lw_lat", 32'(lat), 32'd2);
        req0(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        req0(1'b1, 1'b0, 32'h101, 32'h0, 2'b01, 1'b0, lat, rdv, errv);
        check("err_lh_mis", 32'(errv), 32'd1);
        check("err_lh_rd", rdv, 32'd0);
        req0(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0, lat, rdv, errv);
        check("err_size11", 32'(errv), 32'd1);
        req0(1'b1, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        check("err_rdwr", 32'(errv), 32'd1);
        req0(1'b0, 1'b1, 32'h102, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        check("err_sw_mis", 32'(errv), 32'd1);
        req0(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        check("err_ram_kept", rdv, 32'hABCD1234);
        check("ok_after_err", 32'(errv), 32'd0);

        // Address aliasing: 0x100 + 4*1024
        req0(1'b1, 1'b0, 32'h1100, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        check("alias_ld", rdv, 32'hABCD1234);
        req0(1'b0, 1'b1, 32'h1100, 32'h00000055, 2'b00, 1'b0, lat, rdv, errv);
        req0(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        check("alias_st", rdv, 32'hABCD1255);

        // Reset during ACCESS of a store
        req0(1'b0, 1'b1, 32'h200, 32'h11111111, 2'b10, 1'b0, lat, rdv, errv);
        @(negedge clk);
        addr0 = 32'h200; wdata0 = 32'h12345678; size0 = 2'b10; wren0 = 1'b1;
        @(negedge clk);
        wren0 = 1'b0;
        check("pre_rst_busy", 32'(ready0), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack0), 32'd0);
        check("rst_mid_rd", rd0, 32'd0);
        check("rst_mid_ready", 32'(ready0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int acks = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (ack0) acks++;
            end
            check("rst_no_ack", 32'(acks), 32'd0);
        end
        req0(1'b1, 1'b0, 32'h200, 32'h0, 2'b10, 1'b0, lat, rdv, errv);
        check("rst_discard", rdv, 32'h11111111);

        // Three wait states: SW, ignored change while busy, back-to-back LW
        begin
            int low = 0, first = 0, second = 0, acks = 0;
            logic [31:0] ld = '0;
            @(negedge clk);
            addr3 = 32'h40; wdata3 = 32'hCAFEF00D; size3 = 2'b10; wren3 = 1'b1;
            check("ws_ready0", 32'(ready3), 32'd1);
            @(negedge clk);
            for (int c = 1; c <= 14; c++) begin
                if (c > 1) @(negedge clk);
                if (c <= 4 && !ready3) low++;
                if (ack3) begin
                    acks++;
                    if (first == 0) first = c;
                    else if (second == 0) begin
                        second = c;
                        ld = rd3;
                    end
                end
                if (c == 1) wdata3 = 32'h00000BAD;
                if (c == 4) begin
                    wren3 = 1'b0; rden3 = 1'b1;
                end
                if (c == 6) rden3 = 1'b0;
            end
            check("ws_ready_low", 32'(low), 32'd4);
            check("ws_sw_ack", 32'(first), 32'd5);
            check("ws_lw_ack", 32'(second), 32'd10);
            check("ws_lw_data", ld, 32'hCAFEF00D);
            check("ws_ack_count", 32'(acks), 32'd2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
